sample_scheduler: RTL and testbench

Sequences ADC conversions at the sample rate chosen by the frequency-control block. Collects fixed-length frames and hands samples downstream over a valid/ready stream. Sits between the frequency-control block (`div`/`stable`) and the ADC front end. Applies divider changes only at safe conversion boundaries and restarts the frame, so a frame never mixes sample rates.

---
 rtl/sample_sched_pkg.sv | 14 +
 rtl/sample_tick_gen.sv | 36 +++
 rtl/sample_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_sample_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// Optional build macro: SAMPLE_SCHED_OVERRUN_CNT_EN (see sample_scheduler).
package sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } sched_state_t;

    localparam int DIV_RESET = 14;
    localparam int OVR_CNT_W = 16;

endpackage

// File: rtl/sample_tick_gen.sv
// Conversion tick counter: counts 0..period, tick in the terminal cycle.
// Build macro SAMPLE_SCHED_OVERRUN_CNT_EN has no effect here.
module sample_tick_gen #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == period);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Paces ADC conversions, frames samples, and restarts frames on divider changes.
// Define SAMPLE_SCHED_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int DIV_WIDTH  = 12,
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 1024,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  div_in,
    input  logic                  stable,
    input  logic                  frame_req,
    output logic                  adc_start,
    input  logic                  adc_done,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sample_last,
    output logic                  frame_abort,
    output logic                  busy,
    output logic                  overrun,
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    output logic [OVR_CNT_W-1:0]  overrun_cnt,
`endif
    output logic [DIV_WIDTH-1:0]  div_active
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    sched_state_t          state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  div_pend_q, div_pend_d;
    logic                  pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  abort_q, abort_d;
    logic                  outst_q, outst_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic tick;
    logic tick_en;
    logic tick_clr;
    logic hs;
    logic last;
    logic done_last;
    logic flush_go;
    logic drop;

    assign hs        = valid_q && sample_ready;
    assign last      = valid_q && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign done_last = hs && last;
    assign flush_go  = (state_q == RUN) && tick && pend_q;
    assign tick_en   = (state_q == RUN);
    assign tick_clr  = (state_q != RUN) || done_last;

    // A pending divider change steals the wrap strobe so no conversion spans rates.
    assign adc_start = (state_q == RUN) && tick && !pend_q && !done_last;

    sample_tick_gen #(
        .W(DIV_WIDTH)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_en),
        .clr   (tick_clr),
        .period(div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        abort_d    = 1'b0;
        outst_d    = outst_q;
        tmo_d      = '0;
        drop       = 1'b0;

        if (hs) begin
            valid_d = 1'b0;
        end
        if (adc_start) begin
            outst_d = 1'b1;
        end else if (adc_done) begin
            outst_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!stable) begin
                    div_d  = div_in;
                    pend_d = 1'b0;
                end
                if (frame_req) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!stable) begin
                    div_pend_d = div_in;
                    pend_d     = 1'b1;
                end
                if (adc_done && !done_last) begin
                    if (!valid_q || hs) begin
                        data_d  = adc_data;
                        valid_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (done_last) begin
                    state_d = IDLE;
                    if (pend_d) begin
                        div_d  = div_pend_d;
                        pend_d = 1'b0;
                    end
                end else if (flush_go) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!stable) begin
                    div_pend_d = div_in;
                end
                tmo_d = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
                if ((!outst_q || tmo_q >= TMO_W'(TIMEOUT - 1)) && !valid_q) begin
                    state_d = RUN;
                    div_d   = div_pend_d;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    outst_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ovr_d = ovr_q || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= DIV_WIDTH'(DIV_RESET);
            div_pend_q <= DIV_WIDTH'(DIV_RESET);
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            abort_q    <= 1'b0;
            outst_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            abort_q    <= abort_d;
            outst_q    <= outst_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (drop && (ovr_cnt_q != '1)) begin
            ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign sample_last  = last;
    assign frame_abort  = abort_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = ovr_q;
    assign div_active   = div_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed scoreboard bench for sample_scheduler with a 3-cycle ADC responder.
// Checks overrun_cnt when SAMPLE_SCHED_OVERRUN_CNT_EN is defined.
module tb_sample_scheduler;

    localparam int DW = 12;
    localparam int XW = 12;
    localparam int FL = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] div_in = '0;
    logic          stable = 1'b1;
    logic          frame_req = 1'b0;
    logic          adc_start;
    logic          adc_done = 1'b0;
    logic [XW-1:0] adc_data = '0;
    logic [XW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready = 1'b1;
    logic          sample_last;
    logic          frame_abort;
    logic          busy;
    logic          overrun;
    logic [DW-1:0] div_active;
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt;
`endif

    sample_scheduler #(
        .DIV_WIDTH (DW),
        .DATA_WIDTH(XW),
        .FRAME_LEN (FL),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div_in      (div_in),
        .stable      (stable),
        .frame_req   (frame_req),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_last (sample_last),
        .frame_abort (frame_abort),
        .busy        (busy),
        .overrun     (overrun),
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .div_active  (div_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [XW-1:0] sb[$];
    int            sched[$];
    int            starts[$];
    int            aborts[$];
    bit            m_valid = 1'b0;
    int            m_idx = 0;
    int            m_drops = 0;
    logic [XW-1:0] next_data = 12'h0A5;
    bit            mute = 1'b0;
    int            frame_gen = 0;
    int            rst_gen = 0;
    int            seen_gen = 0;
    int            seen_rst = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ADC responder plus output scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        bit done_now;
        bit mhs;
        if (rst_gen != seen_rst) begin
            sched.delete();
            sb.delete();
            m_valid  = 1'b0;
            seen_rst = rst_gen;
        end
        if (frame_gen != seen_gen) begin
            m_idx    = 0;
            seen_gen = frame_gen;
        end
        done_now = 1'b0;
        if (sched.size() > 0 && sched[0] == cyc) begin
            void'(sched.pop_front());
            done_now  = 1'b1;
            next_data = next_data + 12'd37;
        end
        adc_done = done_now;
        adc_data = next_data;
        #1;
        if (!rst) begin
            chk("valid", sample_valid, m_valid);
            mhs = m_valid && sample_ready;
            if (sample_valid && sample_ready) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    chk("data", sample_data, sb[0]);
                    chk("last", sample_last, m_idx == FL - 1);
                    void'(sb.pop_front());
                end
                m_idx++;
            end
            if (done_now) begin
                if (!m_valid || mhs) begin
                    sb.push_back(adc_data);
                    m_valid = 1'b1;
                end else begin
                    m_drops++;
                end
            end else if (mhs) begin
                m_valid = 1'b0;
            end
            if (adc_start) begin
                starts.push_back(cyc);
                if (!mute) sched.push_back(cyc + 3);
            end
            if (frame_abort) aborts.push_back(cyc);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_div_idle(input logic [DW-1:0] v);
        stable = 1'b0;
        div_in = v;
        @(negedge clk);
        stable = 1'b1;
    endtask

    task automatic pulse_stable(input logic [DW-1:0] v);
        stable = 1'b0;
        div_in = v;
        @(negedge clk);
        stable = 1'b1;
    endtask

    task automatic start_frame(output int f);
        starts.delete();
        aborts.delete();
        f = cyc;
        frame_req = 1'b1;
        frame_gen++;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int f, input int exp_end);
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_end_cyc"}, cyc - f, exp_end);
    endtask

    task automatic chk_starts(input string tag, input int f, input int e[6], input int n);
        chk({tag, "_nstart"}, starts.size(), n);
        for (int i = 0; i < n && i < starts.size(); i++) begin
            chk({tag, "_start"}, starts[i] - f, e[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int f;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start", adc_start, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_last", sample_last, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_div", div_active, 14);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic frame at period 15
        set_div_idle(14);
        start_frame(f);
        wait_idle("s1", f, 65);
        repeat (30) @(negedge clk);
        chk_starts("s1", f, '{15, 30, 45, 60, 0, 0}, 4);
        chk("s1_samples", m_idx, 4);
        chk("s1_aborts", aborts.size(), 0);

        // mid-frame change to period 30
        start_frame(f);
        wait_cyc(f + 36);
        pulse_stable(29);
        wait_cyc(f + 46);
        frame_gen++;
        wait_idle("s2", f, 171);
        chk_starts("s2", f, '{15, 30, 76, 106, 136, 166}, 6);
        chk("s2_naborts", aborts.size(), 1);
        if (aborts.size() > 0) chk("s2_abort_cyc", aborts[0] - f, 47);
        chk("s2_div", div_active, 29);
        chk("s2_samples", m_idx, 4);

        // backpressure overrun
        set_div_idle(14);
        start_frame(f);
        wait_cyc(f + 19);
        sample_ready = 1'b0;
        wait_cyc(f + 33);
        chk("s3_ovr_pre", overrun, 0);
        wait_cyc(f + 50);
        chk("s3_ovr", overrun, 1);
        if (sb.size() > 0) chk("s3_held", sample_data, sb[0]);
        wait_cyc(f + 59);
        sample_ready = 1'b1;
        wait_idle("s3", f, 95);
        chk_starts("s3", f, '{15, 30, 45, 60, 75, 90}, 6);
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        chk("s3_ovr_cnt", overrun_cnt, 2);
`endif

        // flush timeout with an unanswered conversion
        start_frame(f);
        wait_cyc(f + 25);
        mute = 1'b1;
        wait_cyc(f + 35);
        pulse_stable(9);
        wait_cyc(f + 100);
        mute = 1'b0;
        frame_gen++;
        wait_idle("s4", f, 154);
        chk_starts("s4", f, '{15, 30, 119, 129, 139, 149}, 6);
        chk("s4_naborts", aborts.size(), 1);
        if (aborts.size() > 0) chk("s4_abort_cyc", aborts[0] - f, 110);
        chk("s4_div", div_active, 9);

        // ignored request, change on a wrap cycle
        set_div_idle(14);
        start_frame(f);
        wait_cyc(f + 5);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        wait_cyc(f + 15);
        pulse_stable(9);
        wait_cyc(f + 31);
        frame_gen++;
        wait_idle("s5", f, 76);
        chk_starts("s5", f, '{15, 41, 51, 61, 71, 0}, 5);
        chk("s5_naborts", aborts.size(), 1);
        if (aborts.size() > 0) chk("s5_abort_cyc", aborts[0] - f, 32);
        chk("s5_ovr_sticky", overrun, 1);

        // reset mid-frame with a held sample
        start_frame(f);
        wait_cyc(f + 12);
        sample_ready = 1'b0;
        wait_cyc(f + 19);
        chk("s6_pre_busy", busy, 1);
        chk("s6_pre_valid", sample_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        rst_gen++;
        #1;
        chk("s6_start", adc_start, 0);
        chk("s6_valid", sample_valid, 0);
        chk("s6_last", sample_last, 0);
        chk("s6_abort", frame_abort, 0);
        chk("s6_busy", busy, 0);
        chk("s6_ovr", overrun, 0);
        chk("s6_data", sample_data, 0);
        chk("s6_div", div_active, 14);
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        chk("s6_ovr_cnt", overrun_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sample_ready = 1'b1;
        starts.delete();
        repeat (30) @(negedge clk);
        chk("s6_post_starts", starts.size(), 0);
        chk("s6_post_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
